serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl_pkg.sv | 11 +
 rtl/serial_add_ctrl_if.sv | 26 ++
 rtl/serial_add_ctrl_chk.sv | 11 +
 rtl/serial_add_ctrl_full_adder_bit.sv | 31 +++
 rtl/serial_add_ctrl.sv | 125 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 209 ++++++++++++++++++++
 6 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the serial-arithmetic controllers.
// The state encodings are fixed so that later controllers can reuse them.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requester and the serial adder controller.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  import serial_add_ctrl_pkg::*;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b,
    input  ready, busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, sum, cout
  );

endinterface

// File: rtl/serial_add_ctrl_chk.sv
// Simulation-only check: start must be a clean 0/1 whenever the controller can accept it.
module serial_add_ctrl_chk (
  input logic clk,
  input logic rst,
  input logic ready,
  input logic start
);

  start_known: assert property (@(posedge clk) disable iff (rst) ready |-> !$isunknown(start));

endmodule

// File: rtl/serial_add_ctrl_full_adder_bit.sv
// One-bit adder cell: two half adders, with their carries ORed together.
module half_adder (
  output logic s,
  output logic c,
  input  logic a,
  input  logic b
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module full_adder_bit (
  output logic s,
  output logic c,
  input  logic x,
  input  logic y,
  input  logic cin
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (.s(s0), .c(c0), .a(x),  .b(y));
  half_adder u_ha1 (.s(s),  .c(c1), .a(s0), .b(cin));

  assign c = c0 | c1;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: runs one full_adder_bit over two WIDTH-bit operands,
// LSB first, one bit per clock, behind a start/ready/busy/done handshake.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic              clk,
  input logic              rst,
  serial_add_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   sum_shift;
  logic [CNT_W-1:0] count;
  logic             carry;
  logic             cout;
  logic             busy;
  logic             done;
  logic             cell_s;
  logic             cell_c;
  logic             load;
  logic             step;
  logic             last;

  full_adder_bit u_cell (
    .s   (cell_s),
    .c   (cell_c),
    .x   (sa[0]),
    .y   (sb[0]),
    .cin (carry)
  );

  // New sum bit enters at the MSB so the result is LSB-aligned after WIDTH steps.
  assign sum_shift = {cell_s, sum};

  // Next-state and per-cycle control decode.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          next_state = ST_RUN;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (count == LAST_CNT) begin
          last       = 1'b1;
          next_state = ST_DONE;
        end else begin
          next_state = ST_RUN;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State register plus operand shifters, carry, counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      sa    <= '0;
      sb    <= '0;
      sum   <= '0;
      count <= '0;
      carry <= 1'b0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      done  <= last;
      if (load) begin
        sa    <= bus.a;
        sb    <= bus.b;
        carry <= 1'b0;
        count <= '0;
        busy  <= 1'b1;
      end else if (step) begin
        sa    <= sa >> 1;
        sb    <= sb >> 1;
        sum   <= sum_shift[WIDTH:1];
        carry <= cell_c;
        count <= count + CNT_W'(1);
        if (last) begin
          cout <= cell_c;
          busy <= 1'b0;
        end
      end
    end
  end

  assign bus.ready = (state == ST_IDLE);
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.sum   = sum;
  assign bus.cout  = cout;

  serial_add_ctrl_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .ready (bus.ready),
    .start (bus.start)
  );

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: a timing/arithmetic model checked every cycle on an
// 8-bit instance, plus directed literal cases including a 1-bit instance.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errs   = 0;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();
  serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_add_ctrl #(.WIDTH(W)) dut  (.clk(clk), .rst(rst), .bus(bus));
  serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted request occupies W+2 edges; the result is a plain 9-bit sum.
  int         t_left;
  logic [8:0] exp_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t_left  <= 0;
      exp_res <= 9'd0;
    end else if (t_left == 0) begin
      if (bus.start === 1'b1) begin
        t_left  <= W + 1;
        exp_res <= {1'b0, bus.a} + {1'b0, bus.b};
      end
    end else begin
      t_left <= t_left - 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("ready", bus.ready, t_left == 0);
      chk("busy",  bus.busy,  t_left >= 2);
      chk("done",  bus.done,  t_left == 1);
      if (t_left <= 1) begin
        chk("sum",  bus.sum,  exp_res[7:0]);
        chk("cout", bus.cout, exp_res[8]);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (bus.ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", bus.ready, 1'b1);
  endtask

  task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] es, input logic ec);
    int n;
    int busy_n;
    wait_ready();
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
    n      = 1;
    busy_n = bus.busy ? 1 : 0;
    while (bus.done !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
      if (bus.busy === 1'b1) busy_n++;
    end
    chk("latency_edges", n - 1, W);
    chk("busy_cycles", busy_n, W);
    chk("op_sum", bus.sum, es);
    chk("op_cout", bus.cout, ec);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] r;
    logic [7:0] ra;
    logic [7:0] rb;
    int         cyc;
    int         last_done;
    int         ndone;
    logic [1:0] ab;

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.a      = 8'd0;
    bus.b      = 8'd0;
    bus1.start = 1'b0;
    bus1.a     = 1'b0;
    bus1.b     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.ready, 1'b1);
    chk("rst_busy",  bus.busy,  1'b0);
    chk("rst_done",  bus.done,  1'b0);
    chk("rst_sum",   bus.sum,   8'h00);
    chk("rst_cout",  bus.cout,  1'b0);
    rst = 1'b0;
    @(negedge clk);

    do_op(8'h00, 8'h00, 8'h00, 1'b0);
    do_op(8'h0F, 8'h01, 8'h10, 1'b0);
    do_op(8'hFF, 8'h01, 8'h00, 1'b1);
    do_op(8'hAA, 8'h55, 8'hFF, 1'b0);
    do_op(8'hFF, 8'hFF, 8'hFE, 1'b1);

    // start held high, operands scrambled every cycle
    wait_ready();
    bus.start = 1'b1;
    cyc       = 0;
    last_done = -1;
    ndone     = 0;
    while (ndone < 3 && cyc < 100) begin
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      @(negedge clk);
      cyc++;
      if (bus.done === 1'b1) begin
        if (ndone > 0) chk("held_start_spacing", cyc - last_done, W + 2);
        last_done = cyc;
        ndone++;
      end
    end
    chk("held_start_ops", ndone, 3);
    bus.start = 1'b0;

    // asynchronous reset on the 4th RUN cycle
    wait_ready();
    bus.start = 1'b1;
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", bus.busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy",  bus.busy,  1'b0);
    chk("abort_done",  bus.done,  1'b0);
    chk("abort_sum",   bus.sum,   8'h00);
    chk("abort_cout",  bus.cout,  1'b0);
    chk("abort_ready", bus.ready, 1'b1);
    #1;
    rst   = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    do_op(8'h7F, 8'h81, 8'h00, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      r  = {1'b0, ra} + {1'b0, rb};
      do_op(ra, rb, r[7:0], r[8]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // 1-bit instance: half-adder truth table, done one cycle after accept
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      @(negedge clk);
      chk("w1_ready", bus1.ready, 1'b1);
      bus1.start = 1'b1;
      bus1.a     = ab[1];
      bus1.b     = ab[0];
      @(negedge clk);
      bus1.start = 1'b0;
      chk("w1_busy", bus1.busy, 1'b1);
      chk("w1_done_early", bus1.done, 1'b0);
      @(negedge clk);
      chk("w1_done", bus1.done, 1'b1);
      chk("w1_sum",  bus1.sum,  ab[1] ^ ab[0]);
      chk("w1_cout", bus1.cout, ab[1] & ab[0]);
    end
    @(negedge clk);
    chk("w1_done_width", bus1.done, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
